// File: rtl/multicycle_controller.sv
// Multi-cycle instruction sequencer for the 8-bit RISC core: walks each instruction
// through fetch/decode/execute/writeback, handshakes with instruction memory, counts retirements.

`ifndef NOP
`define NOP  3'b000
`endif
`ifndef RADD
`define RADD 3'b001
`endif
`ifndef RSUB
`define RSUB 3'b010
`endif
`ifndef RSRL
`define RSRL 3'b011
`endif
`ifndef RSLL
`define RSLL 3'b100
`endif

module multicycle_controller #(
  parameter int OPW     = 3,
  parameter int EXW     = 3,
  parameter int EXE_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OPW-1:0]   opcode,
  input  logic             imem_ack,
  input  logic             BLT,
  input  logic             BEQ,
  input  logic             halt,
  output logic             imem_req,
  output logic             PCincr,
  output logic             PCbranch,
  output logic [EXW-1:0]   EXE_CMD,
  output logic             ImSel,
  output logic             Reg_w,
  output logic             branchEn,
  output logic             busy,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam int CW = 4;

  localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(1);
  localparam logic [OPW-1:0] OP_SRL  = OPW'(2);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(3);
  localparam logic [OPW-1:0] OP_SLLI = OPW'(4);
  localparam logic [OPW-1:0] OP_BLT  = OPW'(5);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(6);
  localparam logic [OPW-1:0] OP_J    = OPW'(7);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, WB, BRANCH, JUMP
  } state_t;

  state_t          state;
  logic [OPW-1:0]  op_q;
  logic [CW-1:0]   count;
  logic [EXW-1:0]  alu_cmd;
  logic            imm_sel;
  logic            legal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      op_q    <= '0;
      count   <= '0;
      retired <= '0;
    end else begin
      case (state)
        IDLE:  state <= FETCH;
        FETCH: begin
          if (!halt && imem_ack) begin
            op_q  <= opcode;
            state <= DECODE;
          end
        end
        DECODE: begin
          case (op_q)
            OP_ADD, OP_SUB, OP_SRL, OP_ADDI, OP_SLLI: begin
              state <= EXEC;
              count <= CW'(EXE_LAT - 1);
            end
            OP_BLT, OP_BEQ: state <= BRANCH;
            OP_J:           state <= JUMP;
            default:        state <= FETCH;
          endcase
        end
        EXEC: begin
          // count was preloaded with EXE_LAT-1, so the dwell is exactly EXE_LAT cycles
          if (count == '0) state <= WB;
          else             count <= count - 1'b1;
        end
        WB, BRANCH, JUMP: begin
          if (retired != '1) retired <= retired + 1'b1;
          state <= FETCH;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ALU command and immediate select are a pure function of the latched opcode
  always_comb begin
    alu_cmd = EXW'(`NOP);
    imm_sel = 1'b0;
    legal   = 1'b1;
    case (op_q)
      OP_ADD:  alu_cmd = EXW'(`RADD);
      OP_ADDI: begin alu_cmd = EXW'(`RADD); imm_sel = 1'b1; end
      OP_SUB:  alu_cmd = EXW'(`RSUB);
      OP_SRL:  alu_cmd = EXW'(`RSRL);
      OP_SLLI: begin alu_cmd = EXW'(`RSLL); imm_sel = 1'b1; end
      OP_BLT, OP_BEQ, OP_J: ;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    PCincr   = 1'b0;
    PCbranch = 1'b0;
    EXE_CMD  = EXW'(`NOP);
    ImSel    = 1'b0;
    Reg_w    = 1'b0;
    branchEn = 1'b0;
    illegal  = 1'b0;
    busy     = 1'b0;
    case (state)
      FETCH: begin
        imem_req = ~halt;
        PCincr   = ~halt & imem_ack;
      end
      DECODE: begin
        busy    = 1'b1;
        illegal = ~legal;
      end
      EXEC: begin
        busy    = 1'b1;
        EXE_CMD = alu_cmd;
        ImSel   = imm_sel;
      end
      WB: begin
        busy    = 1'b1;
        EXE_CMD = alu_cmd;
        ImSel   = imm_sel;
        Reg_w   = 1'b1;
      end
      BRANCH: begin
        busy     = 1'b1;
        branchEn = 1'b1;
        PCbranch = (op_q == OP_BLT) ? BLT : BEQ;
      end
      JUMP: begin
        busy     = 1'b1;
        PCbranch = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized check of multicycle_controller: two instances (EXE_LAT=1/CNT_W=16/OPW=3 and
// EXE_LAT=4/CNT_W=2/OPW=4) compared against a per-instruction timeline model.

module tb_multicycle_controller;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SRL = 4'd2, OP_ADDI = 4'd3,
                         OP_SLLI = 4'd4, OP_BLT = 4'd5, OP_BEQ = 4'd6, OP_J = 4'd7;
  localparam logic [2:0] A_NOP = 3'd0, A_RADD = 3'd1, A_RSUB = 3'd2, A_RSRL = 3'd3, A_RSLL = 3'd4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b, sel;
  logic       halt, ack, blt, beq;
  logic [3:0] op;
  logic       halt_a, halt_b;

  logic       req_a, incr_a, br_a, ims_a, rw_a, ben_a, busy_a, ill_a;
  logic [2:0] cmd_a;
  logic [15:0] ret_a;
  logic       req_b, incr_b, br_b, ims_b, rw_b, ben_b, busy_b, ill_b;
  logic [2:0] cmd_b;
  logic [1:0] ret_b;

  assign halt_a = sel ? 1'b1 : halt;
  assign halt_b = sel ? halt : 1'b1;

  multicycle_controller #(.OPW(3), .EXW(3), .EXE_LAT(1), .CNT_W(16)) dut_a (
    .clk(clk), .reset(rst_a), .opcode(op[2:0]), .imem_ack(ack), .BLT(blt), .BEQ(beq),
    .halt(halt_a), .imem_req(req_a), .PCincr(incr_a), .PCbranch(br_a), .EXE_CMD(cmd_a),
    .ImSel(ims_a), .Reg_w(rw_a), .branchEn(ben_a), .busy(busy_a), .illegal(ill_a),
    .retired(ret_a)
  );

  multicycle_controller #(.OPW(4), .EXW(3), .EXE_LAT(4), .CNT_W(2)) dut_b (
    .clk(clk), .reset(rst_b), .opcode(op), .imem_ack(ack), .BLT(blt), .BEQ(beq),
    .halt(halt_b), .imem_req(req_b), .PCincr(incr_b), .PCbranch(br_b), .EXE_CMD(cmd_b),
    .ImSel(ims_b), .Reg_w(rw_b), .branchEn(ben_b), .busy(busy_b), .illegal(ill_b),
    .retired(ret_b)
  );

  logic [10:0] vec_a, vec_b, obs_vec;
  logic [31:0] obs_ret;
  assign vec_a   = {req_a, incr_a, br_a, cmd_a, ims_a, rw_a, ben_a, busy_a, ill_a};
  assign vec_b   = {req_b, incr_b, br_b, cmd_b, ims_b, rw_b, ben_b, busy_b, ill_b};
  assign obs_vec = sel ? vec_b : vec_a;
  assign obs_ret = sel ? 32'(ret_b) : 32'(ret_a);

  int n_tests = 0;
  int n_fail  = 0;
  int ret_model = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] v(input logic req, input logic incr, input logic br,
                                    input logic [2:0] cmd, input logic ims, input logic rw,
                                    input logic ben, input logic bsy, input logic ill);
    return {req, incr, br, cmd, ims, rw, ben, bsy, ill};
  endfunction

  function automatic logic [2:0] exp_cmd(input logic [3:0] o);
    case (o)
      OP_ADD, OP_ADDI: return A_RADD;
      OP_SUB:          return A_RSUB;
      OP_SRL:          return A_RSRL;
      OP_SLLI:         return A_RSLL;
      default:         return A_NOP;
    endcase
  endfunction

  // One clock of the timeline: inputs are already driven, sample at negedge, advance past posedge.
  task automatic cyc(input string tag, input logic [10:0] e);
    @(negedge clk);
    check(tag, 32'(obs_vec), 32'(e));
    check({tag, "_ret"}, obs_ret, 32'(ret_model));
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    halt = 1'($urandom);
    ack  = 1'($urandom);
    op   = 4'($urandom);
    blt  = 1'($urandom);
    beq  = 1'($urandom);
  endtask

  task automatic bump();
    int rmax;
    rmax = sel ? 3 : 65535;
    if (ret_model < rmax) ret_model++;
  endtask

  // Expected behaviour of one instruction starting with the controller in FETCH.
  task automatic run_instr(input int nh, input int nw, input logic [3:0] opc, input logic fb);
    int lat;
    logic [3:0] o;
    logic legal, exp_br;
    lat   = sel ? 4 : 1;
    o     = sel ? opc : {1'b0, opc[2:0]};
    legal = (o < 4'd8);
    $display("[TB] dut%0d op=%0d halt_cycles=%0d wait_cycles=%0d flag=%0d retired_before=%0d",
             sel, o, nh, nw, fb, ret_model);
    for (int i = 0; i < nh; i++) begin
      halt = 1'b1; ack = 1'($urandom); op = 4'($urandom);
      cyc("fetch_halt", v(0, 0, 0, A_NOP, 0, 0, 0, 0, 0));
    end
    for (int i = 0; i < nw; i++) begin
      halt = 1'b0; ack = 1'b0; op = 4'($urandom);
      cyc("fetch_wait", v(1, 0, 0, A_NOP, 0, 0, 0, 0, 0));
    end
    halt = 1'b0; ack = 1'b1; op = opc;
    cyc("fetch_ack", v(1, 1, 0, A_NOP, 0, 0, 0, 0, 0));
    noise();
    cyc("decode", v(0, 0, 0, A_NOP, 0, 0, 0, 1, ~legal));
    if (legal && o <= OP_SLLI) begin
      for (int i = 0; i < lat; i++) begin
        noise();
        cyc("exec", v(0, 0, 0, exp_cmd(o), (o == OP_ADDI || o == OP_SLLI), 0, 0, 1, 0));
      end
      noise();
      cyc("wb", v(0, 0, 0, exp_cmd(o), (o == OP_ADDI || o == OP_SLLI), 1, 0, 1, 0));
      bump();
    end else if (legal && (o == OP_BLT || o == OP_BEQ)) begin
      noise();
      if (o == OP_BLT) blt = fb; else beq = fb;
      exp_br = fb;
      cyc("branch", v(0, 0, exp_br, A_NOP, 0, 0, 1, 1, 0));
      bump();
    end else if (legal) begin
      noise();
      cyc("jump", v(0, 0, 1, A_NOP, 0, 0, 0, 1, 0));
      bump();
    end
  endtask

  task automatic release_reset();
    if (sel) rst_b = 1'b0; else rst_a = 1'b0;
    ret_model = 0;
    noise();
    cyc("idle", v(0, 0, 0, A_NOP, 0, 0, 0, 0, 0));
  endtask

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++)
      run_instr($urandom_range(0, 2), $urandom_range(0, 3), 4'($urandom), 1'($urandom));
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; sel = 1'b0;
    halt = 1'b0; ack = 1'b0; op = '0; blt = 1'b0; beq = 1'b0;
    @(posedge clk); #1;
    noise();
    cyc("reset_a", v(0, 0, 0, A_NOP, 0, 0, 0, 0, 0));
    sel = 1'b1;
    noise();
    cyc("reset_b", v(0, 0, 0, A_NOP, 0, 0, 0, 0, 0));

    sel = 1'b0;
    release_reset();
    run_instr(0, 0, OP_ADD, 1'b0);
    run_instr(0, 0, OP_BEQ, 1'b1);
    run_instr(0, 0, OP_BLT, 1'b0);
    run_instr(0, 3, OP_SUB, 1'b0);
    run_instr(3, 1, OP_ADDI, 1'b0);
    run_random(40);

    sel = 1'b1;
    release_reset();
    run_instr(0, 0, OP_SLLI, 1'b0);
    ret_model = 0;
    rst_b = 1'b1;
    #1;
    release_reset();
    for (int i = 0; i < 5; i++) run_instr(0, 0, OP_J, 1'b0);
    run_instr(0, 0, 4'hA, 1'b0);
    run_instr(1, 2, 4'hF, 1'b0);
    run_random(30);

    // Asynchronous reset in the second EXEC cycle of an SLLI
    $display("[TB] dut1 async reset mid-EXEC, retired_before=%0d", ret_model);
    halt = 1'b0; ack = 1'b1; op = OP_SLLI;
    cyc("rx_fetch", v(1, 1, 0, A_NOP, 0, 0, 0, 0, 0));
    noise();
    cyc("rx_decode", v(0, 0, 0, A_NOP, 0, 0, 0, 1, 0));
    noise();
    cyc("rx_exec1", v(0, 0, 0, A_RSLL, 1, 0, 0, 1, 0));
    noise();
    @(negedge clk);
    check("rx_exec2", 32'(obs_vec), 32'(v(0, 0, 0, A_RSLL, 1, 0, 0, 1, 0)));
    rst_b = 1'b1;
    ret_model = 0;
    #1;
    check("rx_async_out", 32'(obs_vec), 32'(0));
    check("rx_async_ret", obs_ret, 32'(0));
    @(posedge clk); #1;
    noise();
    cyc("rx_hold", v(0, 0, 0, A_NOP, 0, 0, 0, 0, 0));
    release_reset();
    run_instr(0, 0, OP_ADD, 1'b0);
    run_instr(0, 1, OP_J, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Multi-cycle successor to the single-cycle instruction decoder of the 8-bit RISC core. It sequences each instruction through fetch, decode, execute/branch and writeback states, and handshakes with instruction memory. It supports a configurable-latency ALU and keeps a retired-instruction counter. It sits between instruction memory, PC logic, ALU and register file, and emits the same control set, timed per state.

Parameters:
OPW, 3, opcode width; opcode = top OPW bits of instruction
EXW, 3, EXE_CMD width, using the ALU command codes in alucodes.sv
EXE_LAT, 1, cycles spent in EXEC per ALU instruction (legal range 1..15)
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
opcode  in  OPW  opcode from instruction memory data, valid when imem_ack=1
imem_ack  in  1  instruction memory has data this cycle
BLT  in  1  ALU less-than flag
BEQ  in  1  ALU equal flag
halt  in  1  suppress new fetches
imem_req  out  1  request instruction fetch
PCincr  out  1  PC += 1 pulse
PCbranch  out  1  PC load-target pulse
EXE_CMD  out  EXW  ALU command
ImSel  out  1  immediate mux select
Reg_w  out  1  register-file write enable
branchEn  out  1  branch compare cycle
busy  out  1  instruction in flight (state not IDLE/FETCH)
illegal  out  1  one-cycle pulse on undecodable opcode
retired  out  CNT_W  retired-instruction count, saturating

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, WB, BRANCH, JUMP. State, opcode register op_q, latency counter and retired are registered.
- All outputs are combinational from state, op_q and inputs. Default for every output is 0; EXE_CMD defaults to `NOP.
- Reset (async, any time, including mid-instruction):
  - state=IDLE, op_q=0, counter=0, retired=0.
  - All outputs are 0 while reset is high; EXE_CMD=`NOP.
  - An in-flight instruction is abandoned; no Reg_w or PCbranch is issued for it.
- IDLE: all outputs 0; next state FETCH unconditionally.
- FETCH:
  - imem_req = ~halt.
  - If ~halt and imem_ack: PCincr=1 this cycle, op_q<=opcode, next state DECODE.
  - Otherwise remain in FETCH. imem_ack while halt=1 is ignored.
- DECODE (1 cycle), next state by op_q:
  - ADD/SUB/SRL/ADDI/SLLI -> EXEC, counter<=EXE_LAT-1.
  - BLT/BEQ -> BRANCH.
  - J -> JUMP.
  - Any other encoding (OPW>3 only) -> FETCH, illegal=1 this cycle; retired is not incremented.
- EXEC:
  - EXE_CMD held for the whole state: ADD,ADDI->`RADD; SUB->`RSUB; SRL->`RSRL; SLLI->`RSLL.
  - ImSel=1 for ADDI/SLLI.
  - Counter decrements each cycle; when it reaches 0, next state is WB.
  - Dwell is exactly EXE_LAT cycles.
- WB (1 cycle): EXE_CMD and ImSel held, Reg_w=1; retired increments; next state FETCH.
- BRANCH (1 cycle):
  - branchEn=1.
  - PCbranch = BLT flag for opcode BLT, BEQ flag for opcode BEQ, sampled this cycle.
  - retired increments; next state FETCH.
- JUMP (1 cycle): PCbranch=1; retired increments; next state FETCH.
- Latency with zero-wait memory:
  - ALU instruction: 3+EXE_LAT cycles.
  - Branch or jump: 3 cycles.
  - Each memory wait cycle adds 1.
- Invariants: PCincr and PCbranch are never both high. Reg_w is high only in WB.
- retired saturates at all-ones and does not wrap.
- busy=1 in DECODE, EXEC, WB, BRANCH and JUMP.

Test Plan:
- Reset release, EXE_LAT=1, imem_ack=1, opcode=ADD:
  - IDLE, then FETCH with imem_req=1 and PCincr=1, then DECODE, then EXEC with EXE_CMD=`RADD and ImSel=0, then WB with Reg_w=1.
  - retired=1 after 5 clocks from release.
- EXE_LAT=4, opcode=SLLI:
  - EXE_CMD=`RSLL and ImSel=1 for exactly 5 consecutive cycles (4 EXEC + WB).
  - Reg_w=1 on the 5th cycle only.
- BEQ with BEQ flag=1: branchEn=1 and PCbranch=1 in the same cycle. BLT with BLT flag=0: branchEn=1, PCbranch=0. retired increments by 1 in both cases.
- imem_ack held low 3 cycles, then high:
  - imem_req=1 for 4 cycles; PCincr=1 only on the ack cycle.
  - halt=1 during FETCH forces imem_req=0 and no state advance.
- reset asserted mid-EXEC (EXE_LAT=4, 2nd EXEC cycle): all outputs 0 immediately (asynchronous), no Reg_w pulse, retired=0, restart from IDLE.
- CNT_W=2, run 5 jump instructions: retired reads 1, 2, 3, 3, 3. OPW=4 with an undefined opcode: illegal pulses 1 cycle in DECODE and retired is unchanged.
